// File: rtl/acq_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acq_seq_pkg                                                                |
// | Shared types and constants for the acquisition sequencer.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package acq_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } acq_state_t;

    localparam logic [31:0] AGC_RST_WORD  = 32'h0000_0AAA;
    localparam logic [31:0] CTRL_RST_WORD = 32'h0000_0024;
    localparam int          FRAME_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/acq_event_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acq_event_gen                                                              |
// | Registered equality hit of the frame counter against one event time.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acq_event_gen #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 i_en,
    input  logic [CNT_WIDTH-1:0] i_cnt_nxt,
    input  logic [CNT_WIDTH-1:0] i_time_nxt,
    output logic                 o_hit
);

    // Compares next-cycle values so o_hit is high in the same cycle cnt == time.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            o_hit <= 1'b0;
        end else begin
            o_hit <= i_en && (i_cnt_nxt == i_time_nxt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acq_sequencer                                                              |
// | Frame counter, FSM and event strobes for AGC load and ADC control/enable.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int N_CH       = 2,
    parameter int CTRL_WIDTH = 10,
    parameter int AGC_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cfg_continuous,
    input  logic [CNT_WIDTH-1:0]   cfg_period,
    input  logic [CNT_WIDTH-1:0]   cfg_t_agc,
    input  logic [CNT_WIDTH-1:0]   cfg_t_ld,
    input  logic [CNT_WIDTH-1:0]   cfg_t_en,
    input  logic [CNT_WIDTH-1:0]   cfg_t_dis,
    input  logic [AGC_WIDTH-1:0]   cfg_agc_data,
    input  logic [CTRL_WIDTH-1:0]  cfg_ctrlword,
    input  logic [N_CH-1:0]        cfg_ch_mask,
    input  logic [N_CH-1:0]        adc_mbusy,
    output logic                   agc_load,
    output logic [AGC_WIDTH-1:0]   agc_data,
    output logic [N_CH-1:0]        adc_ldctrl,
    output logic [CTRL_WIDTH-1:0]  adc_ctrlword,
    output logic [N_CH-1:0]        adc_enable,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   cfg_err
);

    localparam int c_ev_agc = 0;
    localparam int c_ev_ld  = 1;
    localparam int c_ev_en  = 2;
    localparam int c_ev_dis = 3;
    localparam int c_n_ev   = 4;

    acq_state_t             r_state;
    acq_state_t             w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   r_pm1;
    logic [CNT_WIDTH-1:0]   r_t     [c_n_ev];
    logic [CNT_WIDTH-1:0]   w_cfg_t [c_n_ev];
    logic [CNT_WIDTH-1:0]   w_t_nxt [c_n_ev];
    logic [c_n_ev-1:0]      w_hit;
    logic [N_CH-1:0]        r_mask;
    logic                   r_cont;

    logic                   r_agc_load;
    logic [AGC_WIDTH-1:0]   r_agc_data;
    logic [N_CH-1:0]        r_ldctrl;
    logic [CTRL_WIDTH-1:0]  r_ctrlword;
    logic [N_CH-1:0]        r_enable;
    logic                   r_busy;
    logic [FRAME_CNT_W-1:0] r_frame;
    logic                   r_err;

    logic w_idle_req;
    logic w_accept;
    logic w_reject;
    logic w_adv;
    logic w_wrap;
    logic w_mbusy_clr;
    logic w_gen_en;

    // Stop has priority over start when both arrive together in IDLE.
    assign w_idle_req  = (r_state == ST_IDLE) && start && !stop;
    assign w_accept    = w_idle_req && (cfg_period >= CNT_WIDTH'(2));
    assign w_reject    = w_idle_req && (cfg_period <  CNT_WIDTH'(2));
    assign w_adv       = (r_state == ST_RUN) && !stop;
    assign w_wrap      = (r_cnt == r_pm1);
    assign w_mbusy_clr = ((adc_mbusy & r_mask) == '0);
    assign w_gen_en    = (w_state_nxt == ST_RUN);

    always_comb begin
        w_cfg_t[c_ev_agc] = cfg_t_agc;
        w_cfg_t[c_ev_ld]  = cfg_t_ld;
        w_cfg_t[c_ev_en]  = cfg_t_en;
        w_cfg_t[c_ev_dis] = cfg_t_dis;
        for (int i = 0; i < c_n_ev; i++) begin
            w_t_nxt[i] = w_accept ? w_cfg_t[i] : r_t[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_STOPPING;
                end else if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (!r_cont) begin
                        w_state_nxt = ST_STOPPING;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            ST_STOPPING: begin
                if (w_mbusy_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < c_n_ev; gi++) begin : g_evt
        acq_event_gen #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_evt (
            .clk        (clk),
            .arstn      (arstn),
            .i_en       (w_gen_en),
            .i_cnt_nxt  (w_cnt_nxt),
            .i_time_nxt (w_t_nxt[gi]),
            .o_hit      (w_hit[gi])
        );
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pm1   <= '0;
            r_mask  <= '0;
            r_cont  <= 1'b0;
            for (int i = 0; i < c_n_ev; i++) begin
                r_t[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_pm1  <= cfg_period - CNT_WIDTH'(1);
                r_mask <= cfg_ch_mask;
                r_cont <= cfg_continuous;
                for (int i = 0; i < c_n_ev; i++) begin
                    r_t[i] <= w_cfg_t[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_agc_load <= 1'b0;
            r_agc_data <= AGC_RST_WORD[AGC_WIDTH-1:0];
            r_ldctrl   <= '0;
            r_ctrlword <= CTRL_RST_WORD[CTRL_WIDTH-1:0];
            r_enable   <= '0;
            r_busy     <= 1'b0;
            r_frame    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_agc_load <= w_adv && w_hit[c_ev_agc];
            r_ldctrl   <= (w_adv && w_hit[c_ev_ld]) ? r_mask : '0;
            r_err      <= w_reject;
            r_busy     <= (w_state_nxt != ST_IDLE);
            // Disable, stop and one-shot end all outrank an enable in the same cycle.
            if (!w_adv || w_hit[c_ev_dis] || (w_wrap && !r_cont)) begin
                r_enable <= '0;
            end else if (w_hit[c_ev_en]) begin
                r_enable <= r_mask;
            end
            if (w_accept) begin
                r_frame    <= '0;
                r_agc_data <= cfg_agc_data;
                r_ctrlword <= cfg_ctrlword;
            end else if (w_adv && w_wrap && (r_frame != '1)) begin
                r_frame <= r_frame + FRAME_CNT_W'(1);
            end
        end
    end

    assign agc_load     = r_agc_load;
    assign agc_data     = r_agc_data;
    assign adc_ldctrl   = r_ldctrl;
    assign adc_ctrlword = r_ctrlword;
    assign adc_enable   = r_enable;
    assign busy         = r_busy;
    assign frame_cnt    = r_frame;
    assign cfg_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acq_sequencer                                                           |
// | Directed and randomized bench for acq_sequencer against a cycle model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_acq_sequencer;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_t_agc = '0;
    logic [31:0] cfg_t_ld = '0;
    logic [31:0] cfg_t_en = '0;
    logic [31:0] cfg_t_dis = '0;
    logic [11:0] cfg_agc_data = '0;
    logic [9:0]  cfg_ctrlword = '0;
    logic [1:0]  cfg_ch_mask = '0;
    logic [1:0]  adc_mbusy = '0;
    logic        agc_load;
    logic [11:0] agc_data;
    logic [1:0]  adc_ldctrl;
    logic [9:0]  adc_ctrlword;
    logic [1:0]  adc_enable;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        cfg_err;

    always #5 clk = ~clk;

    acq_sequencer #(
        .CNT_WIDTH (32),
        .N_CH      (2),
        .CTRL_WIDTH(10),
        .AGC_WIDTH (12)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .start         (start),
        .stop          (stop),
        .cfg_continuous(cfg_continuous),
        .cfg_period    (cfg_period),
        .cfg_t_agc     (cfg_t_agc),
        .cfg_t_ld      (cfg_t_ld),
        .cfg_t_en      (cfg_t_en),
        .cfg_t_dis     (cfg_t_dis),
        .cfg_agc_data  (cfg_agc_data),
        .cfg_ctrlword  (cfg_ctrlword),
        .cfg_ch_mask   (cfg_ch_mask),
        .adc_mbusy     (adc_mbusy),
        .agc_load      (agc_load),
        .agc_data      (agc_data),
        .adc_ldctrl    (adc_ldctrl),
        .adc_ctrlword  (adc_ctrlword),
        .adc_enable    (adc_enable),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .cfg_err       (cfg_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = counting a frame, 2 = draining ADC busy.
    int          m_mode;
    logic [31:0] m_cnt, s_per, s_tagc, s_tld, s_ten, s_tdis;
    logic [1:0]  s_mask;
    logic        s_cont;
    logic        e_agc_load, e_busy, e_err;
    logic [1:0]  e_ld, e_en;
    logic [15:0] e_frame;
    logic [11:0] e_agcd;
    logic [9:0]  e_cw;

    task automatic model_reset();
        m_mode = 0; m_cnt = '0; s_per = '0; s_tagc = '0; s_tld = '0;
        s_ten = '0; s_tdis = '0; s_mask = '0; s_cont = 1'b0;
        e_agc_load = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_ld = '0; e_en = '0;
        e_frame = '0; e_agcd = 12'hAAA; e_cw = 10'h024;
    endtask

    task automatic model_step();
        e_agc_load = 1'b0; e_ld = '0; e_err = 1'b0;
        case (m_mode)
            0: if (start && !stop) begin
                if (cfg_period < 2) begin
                    e_err = 1'b1;
                end else begin
                    s_per = cfg_period; s_tagc = cfg_t_agc; s_tld = cfg_t_ld;
                    s_ten = cfg_t_en; s_tdis = cfg_t_dis; s_mask = cfg_ch_mask;
                    s_cont = cfg_continuous; m_cnt = '0; e_frame = '0;
                    e_agcd = cfg_agc_data; e_cw = cfg_ctrlword; m_mode = 1;
                end
            end
            1: if (stop) begin
                e_en = '0; m_mode = 2;
            end else begin
                if (m_cnt == s_tagc) e_agc_load = 1'b1;
                if (m_cnt == s_tld)  e_ld = s_mask;
                if (m_cnt == s_ten)  e_en = s_mask;
                if (m_cnt == s_tdis) e_en = '0;
                if (m_cnt == s_per - 1) begin
                    if (e_frame != 16'hFFFF) e_frame = e_frame + 16'd1;
                    if (s_cont) begin
                        m_cnt = '0;
                    end else begin
                        e_en = '0; m_mode = 2;
                    end
                end else begin
                    m_cnt = m_cnt + 32'd1;
                end
            end
            default: if ((adc_mbusy & s_mask) == 2'b00) m_mode = 0;
        endcase
        e_busy = (m_mode != 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!arstn) model_reset();
            else        model_step();
        end
    end

    always @(negedge clk) begin
        check_eq("m_agc_load", agc_load, e_agc_load);
        check_eq("m_ldctrl", adc_ldctrl, e_ld);
        check_eq("m_enable", adc_enable, e_en);
        check_eq("m_busy", busy, e_busy);
        check_eq("m_frame_cnt", frame_cnt, e_frame);
        check_eq("m_cfg_err", cfg_err, e_err);
        check_eq("m_agc_data", agc_data, e_agcd);
        check_eq("m_ctrlword", adc_ctrlword, e_cw);
    end

    task automatic set_cfg(input logic cont, input int per, input int ta, input int tl,
                           input int te, input int td, input logic [1:0] mask);
        cfg_continuous = cont; cfg_period = per; cfg_t_agc = ta; cfg_t_ld = tl;
        cfg_t_en = te; cfg_t_dis = td; cfg_ch_mask = mask;
        cfg_agc_data = 12'h5A5; cfg_ctrlword = 10'h3C3;
    endtask

    task automatic rand_cfg();
        int per;
        per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 40));
        cfg_continuous = 1'($urandom);
        cfg_period = per;
        cfg_t_agc = $urandom_range(0, per + 3);
        cfg_t_ld  = $urandom_range(0, per + 3);
        cfg_t_en  = $urandom_range(0, per + 3);
        cfg_t_dis = $urandom_range(0, per + 3);
        cfg_ch_mask = 2'($urandom);
        cfg_agc_data = 12'($urandom);
        cfg_ctrlword = 10'($urandom);
    endtask

    // Pulses start; returns at the sample point of the cycle busy should rise.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", busy, 1'b1);
    endtask

    initial begin
        logic [1:0] seen_en, seen_ld;
        logic       seen_agc;

        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        check_eq("rst_agc_data", agc_data, 12'hAAA);
        check_eq("rst_ctrlword", adc_ctrlword, 10'h024);
        check_eq("rst_busy", busy, 1'b0);

        // Continuous frames, then asynchronous reset mid-enable of frame 3.
        set_cfg(1'b1, 1000, 10, 500, 600, 900, 2'b11);
        do_start();
        for (int off = 0; off <= 2650; off++) begin
            if (off == 10 || off == 12) check_eq("agc_quiet", agc_load, 1'b0);
            if (off == 11 || off == 1011 || off == 2011) check_eq("agc_at_11", agc_load, 1'b1);
            if (off == 501 || off == 1501) check_eq("ld_at_501", adc_ldctrl, 2'b11);
            if (off == 600 || off == 1600 || off == 901 || off == 1901) check_eq("en_low", adc_enable, 2'b00);
            if (off == 601 || off == 900 || off == 1601 || off == 1900) check_eq("en_high", adc_enable, 2'b11);
            if (off == 999)  check_eq("frame_0", frame_cnt, 16'd0);
            if (off == 1000) check_eq("frame_1", frame_cnt, 16'd1);
            if (off == 2000) check_eq("frame_2", frame_cnt, 16'd2);
            if (off == 2650) begin
                check_eq("pre_rst_en", adc_enable, 2'b11);
                #2 arstn = 1'b0;
                #1;
                check_eq("arst_en", adc_enable, 2'b00);
                check_eq("arst_busy", busy, 1'b0);
                check_eq("arst_frame", frame_cnt, 16'd0);
                check_eq("arst_agc_data", agc_data, 12'hAAA);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        #2 arstn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 1'b0);

        // One-shot frame.
        set_cfg(1'b0, 1000, 10, 500, 600, 900, 2'b11);
        do_start();
        for (int off = 0; off <= 1005; off++) begin
            if (off == 900)  check_eq("os_en_900", adc_enable, 2'b11);
            if (off == 901)  check_eq("os_en_901", adc_enable, 2'b00);
            if (off == 1000) check_eq("os_busy_1000", busy, 1'b1);
            if (off == 1001) check_eq("os_busy_1001", busy, 1'b0);
            if (off == 1005) check_eq("os_frame", frame_cnt, 16'd1);
            @(negedge clk);
        end

        // Stop mid-enable with channel 0 still busy.
        set_cfg(1'b1, 1000, 10, 500, 600, 900, 2'b11);
        do_start();
        for (int off = 0; off <= 745; off++) begin
            if (off == 690) adc_mbusy = 2'b01;
            if (off == 700) stop = 1'b1;
            if (off == 701) begin
                stop = 1'b0;
                check_eq("stop_en_701", adc_enable, 2'b00);
            end
            if (off == 740) begin
                check_eq("stop_busy_740", busy, 1'b1);
                adc_mbusy = 2'b00;
            end
            if (off == 741) check_eq("stop_busy_741", busy, 1'b0);
            @(negedge clk);
        end

        // Rejected start.
        set_cfg(1'b1, 1, 0, 0, 0, 0, 2'b11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("rej_err", cfg_err, 1'b1);
        check_eq("rej_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("rej_err_clr", cfg_err, 1'b0);

        // Equal enable/disable times and out-of-range AGC time.
        set_cfg(1'b0, 1000, 1200, 500, 600, 600, 2'b11);
        seen_en = '0; seen_agc = 1'b0;
        do_start();
        for (int off = 0; off <= 1002; off++) begin
            seen_en |= adc_enable;
            seen_agc |= agc_load;
            @(negedge clk);
        end
        check_eq("eq_en_never", seen_en, 2'b00);
        check_eq("agc_oor_never", seen_agc, 1'b0);

        // Channel mask 01.
        set_cfg(1'b0, 1000, 10, 500, 600, 900, 2'b01);
        seen_en = '0; seen_ld = '0;
        do_start();
        for (int off = 0; off <= 1002; off++) begin
            seen_en |= adc_enable;
            seen_ld |= adc_ldctrl;
            @(negedge clk);
        end
        check_eq("mask_en", seen_en, 2'b01);
        check_eq("mask_ld", seen_ld, 2'b01);

        // Start and stop together in IDLE.
        set_cfg(1'b1, 1000, 10, 500, 600, 900, 2'b11);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check_eq("ss_busy", busy, 1'b0);
        check_eq("ss_err", cfg_err, 1'b0);
        @(negedge clk);
        check_eq("ss_busy2", busy, 1'b0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int r = 0; r < 6; r++) begin
            rand_cfg();
            for (int c = 0; c < 300; c++) begin
                start = ($urandom_range(0, 14) == 0);
                stop  = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 2) == 0) adc_mbusy = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) rand_cfg();
                @(negedge clk);
            end
            start = 1'b0; stop = 1'b1; adc_mbusy = 2'b00;
            @(negedge clk);
            stop = 1'b0;
            repeat (3) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
